// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   - FSM state encodings of the dump sequencer (ST_*)
//   - MEM control constants (byte enables, write-enable levels)
package dmem_port_arbiter_pkg;

  // MEM control defines
  localparam logic       MEM_WE_READ   = 1'b0;
  localparam logic       MEM_WE_WRITE  = 1'b1;
  localparam logic [3:0] FULL_WORD_ENB = 4'b1111;

  // Dump sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/dmem_port_arbiter_dump_seq.sv
// Debug memory-dump sequencer: walks [base, base+len) one word at a time and
// presents each word on a valid/ready output register.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a start pulse
// RD      | wants the memory port; reads when the arbiter grants it
// HOLD    | word captured, o_valid held until the consumer takes it
// DONE    | one-cycle done pulse, back to IDLE
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_start/i_base/i_len  start request and dump range (sampled only in IDLE)
//   i_grant               arbiter gives the port to the dump this cycle (RD)
//   i_mem_rdata           memory read data (same-cycle)
//   i_ready               consumer accepts o_data
//   o_state               current state, used by the arbiter
//   o_rd_addr             word address to read (base+index, wraps)
//   o_busy, o_data, o_valid, o_done   dump status / stream outputs
module dmem_dump_seq
  import dmem_port_arbiter_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10,
  parameter int NB_LEN  = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [NB_ADDR-1:0] i_base,
  input  logic [NB_LEN-1:0]  i_len,
  input  logic               i_grant,
  input  logic [NB_DATA-1:0] i_mem_rdata,
  input  logic               i_ready,
  output logic [1:0]         o_state,
  output logic [NB_ADDR-1:0] o_rd_addr,
  output logic               o_busy,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_done
);

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [NB_ADDR-1:0] r_base;
  logic [NB_LEN-1:0]  r_len;
  logic [NB_LEN-1:0]  r_index;
  logic [NB_DATA-1:0] r_data;
  logic               r_valid;
  logic               r_done;
  logic               w_last;
  logic               w_take;

  assign w_last = (r_index == r_len - NB_LEN'(1));
  assign w_take = r_valid & i_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = (i_len == '0) ? ST_DONE : ST_RD;
      ST_RD:   if (i_grant) w_next = ST_HOLD;
      ST_HOLD: if (w_take)  w_next = w_last ? ST_DONE : ST_RD;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_base  <= '0;
      r_len   <= '0;
      r_index <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Registered so the pulse lines up exactly with the DONE state.
      r_done  <= (w_next == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_base  <= i_base;
            r_len   <= i_len;
            r_index <= '0;
          end
        end
        ST_RD: begin
          if (i_grant) begin
            r_data  <= i_mem_rdata;
            r_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_take) begin
            r_valid <= 1'b0;
            if (!w_last) r_index <= r_index + NB_LEN'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Natural modulo-2^NB_ADDR wrap of the address adder.
  assign o_rd_addr = r_base + NB_ADDR'(r_index);
  assign o_state   = r_state;
  assign o_busy    = (r_state == ST_RD) || (r_state == ST_HOLD);
  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_done    = r_done;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the pipeline MEM stage and the debug dump
// sequencer. The pipeline has priority; a wait counter lets the dump steal a
// single cycle after MAX_WAIT consecutive denials, stalling the pipeline only
// in that cycle.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_pipe_*                       MEM stage request (req/we/byte_enb/addr/wdata)
//   o_pipe_rdata, o_pipe_stall     read data back to MEM, stall when denied
//   i_dbg_start/base/len           dump request
//   o_dbg_busy/data/valid/done     dump status and word stream
//   i_dbg_ready                    stream consumer ready
//   o_mem_*, i_mem_rdata           byte_memory port (combinational read)
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 10,
  parameter int NB_LEN   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pipe_req,
  input  logic               i_pipe_we,
  input  logic [3:0]         i_pipe_byte_enb,
  input  logic [NB_ADDR-1:0] i_pipe_addr,
  input  logic [NB_DATA-1:0] i_pipe_wdata,
  output logic [NB_DATA-1:0] o_pipe_rdata,
  output logic               o_pipe_stall,
  input  logic               i_dbg_start,
  input  logic [NB_ADDR-1:0] i_dbg_base,
  input  logic [NB_LEN-1:0]  i_dbg_len,
  output logic               o_dbg_busy,
  output logic [NB_DATA-1:0] o_dbg_data,
  output logic               o_dbg_valid,
  input  logic               i_dbg_ready,
  output logic               o_dbg_done,
  output logic               o_mem_we,
  output logic [3:0]         o_mem_byte_enb,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  input  logic [NB_DATA-1:0] i_mem_rdata
);

  localparam int NB_WAIT = $clog2(MAX_WAIT + 1);

  logic [1:0]         w_state;
  logic [NB_ADDR-1:0] w_rd_addr;
  logic               w_pipe_wins;
  logic               w_grant;
  logic [NB_WAIT-1:0] r_wait_cnt;

  assign w_pipe_wins = i_pipe_req && (r_wait_cnt < NB_WAIT'(MAX_WAIT));
  // Exactly one owner per cycle: the dump only in RD when the pipeline
  // either is idle or has used up its priority budget.
  assign w_grant     = (w_state == ST_RD) && !w_pipe_wins;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_state == ST_IDLE) begin
      r_wait_cnt <= '0;
    end else if (w_state == ST_RD) begin
      if (w_grant) r_wait_cnt <= '0;
      else         r_wait_cnt <= r_wait_cnt + NB_WAIT'(1);
    end
  end

  dmem_dump_seq #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR),
    .NB_LEN  (NB_LEN)
  ) u_dump_seq (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_dbg_start),
    .i_base      (i_dbg_base),
    .i_len       (i_dbg_len),
    .i_grant     (w_grant),
    .i_mem_rdata (i_mem_rdata),
    .i_ready     (i_dbg_ready),
    .o_state     (w_state),
    .o_rd_addr   (w_rd_addr),
    .o_busy      (o_dbg_busy),
    .o_data      (o_dbg_data),
    .o_valid     (o_dbg_valid),
    .o_done      (o_dbg_done)
  );

  assign o_mem_we       = w_grant ? MEM_WE_READ : (i_pipe_req & i_pipe_we);
  assign o_mem_byte_enb = w_grant ? FULL_WORD_ENB : i_pipe_byte_enb;
  assign o_mem_addr     = w_grant ? w_rd_addr : i_pipe_addr;
  assign o_mem_wdata    = i_pipe_wdata;
  assign o_pipe_rdata   = i_mem_rdata;
  // The denied access is simply not performed; MEM re-presents it.
  assign o_pipe_stall   = w_grant & i_pipe_req;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int NB_DATA  = 32;
  localparam int NB_ADDR  = 10;
  localparam int NB_LEN   = 10;
  localparam int MAX_WAIT = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               pipe_req, pipe_we;
  logic [3:0]         pipe_be;
  logic [NB_ADDR-1:0] pipe_addr;
  logic [NB_DATA-1:0] pipe_wdata, pipe_rdata;
  logic               pipe_stall;
  logic               dbg_start, dbg_busy, dbg_valid, dbg_ready, dbg_done;
  logic [NB_ADDR-1:0] dbg_base;
  logic [NB_LEN-1:0]  dbg_len;
  logic [NB_DATA-1:0] dbg_data;
  logic               mem_we;
  logic [3:0]         mem_be;
  logic [NB_ADDR-1:0] mem_addr;
  logic [NB_DATA-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_LEN(NB_LEN), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pipe_req(pipe_req), .i_pipe_we(pipe_we), .i_pipe_byte_enb(pipe_be),
    .i_pipe_addr(pipe_addr), .i_pipe_wdata(pipe_wdata),
    .o_pipe_rdata(pipe_rdata), .o_pipe_stall(pipe_stall),
    .i_dbg_start(dbg_start), .i_dbg_base(dbg_base), .i_dbg_len(dbg_len),
    .o_dbg_busy(dbg_busy), .o_dbg_data(dbg_data), .o_dbg_valid(dbg_valid),
    .i_dbg_ready(dbg_ready), .o_dbg_done(dbg_done),
    .o_mem_we(mem_we), .o_mem_byte_enb(mem_be), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // byte_memory stand-in: combinational read, byte-enabled write
  logic [NB_DATA-1:0] mem    [0:(1<<NB_ADDR)-1];
  logic [NB_DATA-1:0] shadow [0:(1<<NB_ADDR)-1];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk)
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];

  int n_chk = 0, n_pass = 0;
  logic [NB_DATA-1:0] sb_q[$];
  int ready_mode, bp_cnt, rd_cnt, lat_exp, stall_cnt, done_cnt, busy_cnt, pk, done_base;
  bit held_v, pv, prev_done, prev_stall, pipe_on;
  logic [NB_DATA-1:0] held_d;
  logic [NB_ADDR-1:0] acc_addr[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: sample at the falling edge, then set inputs for the next rise.
  task automatic cycle();
    bit hs;
    @(negedge clk);
    case (ready_mode)
      0: dbg_ready = 1'b1;
      1: begin
        if (dbg_valid) begin
          if (bp_cnt == 4) begin dbg_ready = 1'b1; bp_cnt = 0; end
          else begin dbg_ready = 1'b0; bp_cnt++; end
        end else dbg_ready = 1'b0;
      end
      default: dbg_ready = 1'b0;
    endcase
    hs = dbg_valid && dbg_ready;
    if (dbg_valid && held_v) check("hold_data", dbg_data, held_d);
    if (hs) begin
      if (sb_q.size() == 0) check("sb_extra_word", dbg_data, 32'hFFFF_FFFF);
      else check("dbg_word", dbg_data, sb_q.pop_front());
    end
    held_v = dbg_valid && !hs;
    held_d = dbg_data;
    if (dbg_busy) busy_cnt++;
    if (dbg_busy && !dbg_valid) rd_cnt++;
    if (dbg_valid && !pv) begin
      if (lat_exp != 0) check("rd_latency", rd_cnt, lat_exp);
      rd_cnt = 0;
    end
    pv = dbg_valid;
    if (prev_done) check("done_pulse_width", dbg_done, 1'b0);
    prev_done = dbg_done;
    if (dbg_done) done_cnt++;
    if (pipe_stall) begin
      stall_cnt++;
      check("stall_mem_we", mem_we, 1'b0);
    end
    if (prev_stall) begin
      check("replay_not_stalled", pipe_stall, 1'b0);
      check("replay_we", mem_we, 1'b1);
      check("replay_addr", mem_addr, pipe_addr);
    end
    prev_stall = pipe_stall;
    if (pipe_on) begin
      if (pipe_req && !pipe_stall) begin
        acc_addr.push_back(pipe_addr);
        shadow[pipe_addr] = pipe_wdata;
        pk++;
      end
      pipe_req = 1'b1; pipe_we = 1'b1; pipe_be = 4'hF;
      if (pk == 0) begin pipe_addr = 10'd9; pipe_wdata = 32'h0000_DEAD; end
      else begin pipe_addr = NB_ADDR'(100 + pk); pipe_wdata = 32'hC0DE_0000 + pk; end
    end
  endtask

  task automatic pipe_write(input logic [NB_ADDR-1:0] a, input logic [NB_DATA-1:0] d);
    pipe_req = 1'b1; pipe_we = 1'b1; pipe_be = 4'hF; pipe_addr = a; pipe_wdata = d;
    shadow[a] = d;
    cycle();
    pipe_req = 1'b0; pipe_we = 1'b0;
  endtask

  task automatic pipe_read(input string tag, input logic [NB_ADDR-1:0] a);
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = a;
    #1;
    check(tag, pipe_rdata, shadow[a]);
    check({tag, "_stall"}, pipe_stall, 1'b0);
    cycle();
    pipe_req = 1'b0;
  endtask

  task automatic start_dump(input int b, input int l);
    for (int i = 0; i < l; i++) sb_q.push_back(shadow[NB_ADDR'(b + i)]);
    dbg_start = 1'b1; dbg_base = NB_ADDR'(b); dbg_len = NB_LEN'(l);
    rd_cnt = 0; stall_cnt = 0; busy_cnt = 0; done_base = done_cnt;
    cycle();
    dbg_start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == done_base; i++) cycle();
    check({tag, "_done_count"}, done_cnt, done_base + 1);
    repeat (2) cycle();
    check({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; pipe_req = 0; pipe_we = 0; pipe_be = 0; pipe_addr = 0; pipe_wdata = 0;
    dbg_start = 0; dbg_base = 0; dbg_len = 0; dbg_ready = 0;
    ready_mode = 0; bp_cnt = 0; lat_exp = 0; pk = 0; pipe_on = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", dbg_busy, 1'b0);
    check("rst_valid", dbg_valid, 1'b0);
    check("rst_done", dbg_done, 1'b0);
    check("rst_data", dbg_data, 32'h0);
    check("rst_stall", pipe_stall, 1'b0);
    rst_n = 1'b1;
    cycle();

    pipe_write(10'd5, 32'h11); pipe_write(10'd6, 32'h22); pipe_write(10'd7, 32'h33);
    pipe_write(10'd1023, 32'hAAAA_0001); pipe_write(10'd0, 32'hBBBB_0000);
    pipe_read("pass_rd5", 10'd5);

    // Reset while a word is held
    ready_mode = 2;
    start_dump(5, 3);
    for (int i = 0; i < 20 && !dbg_valid; i++) cycle();
    check("mid_rst_reached_hold", dbg_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", dbg_valid, 1'b0);
    check("mid_rst_busy", dbg_busy, 1'b0);
    sb_q.delete(); held_v = 0; pv = 0;
    done_base = done_cnt;
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    check("mid_rst_no_done", done_cnt, done_base);
    pipe_read("post_rst_rd7", 10'd7);

    // Idle dump
    ready_mode = 0; lat_exp = 1;
    start_dump(5, 3);
    run_until_done("idle", 100);
    check("idle_no_stall", stall_cnt, 0);

    // Backpressure
    ready_mode = 1; bp_cnt = 0;
    start_dump(5, 3);
    run_until_done("bp", 200);

    // Starvation bound under continuous pipeline writes
    ready_mode = 0; lat_exp = MAX_WAIT + 1;
    acc_addr.delete(); pk = 0; pipe_on = 1;
    cycle();
    start_dump(5, 3);
    run_until_done("starve", 200);
    pipe_on = 0; pipe_req = 0; pipe_we = 0;
    cycle();
    check("starve_stalls", stall_cnt, 3);
    check("starve_dead_at_9", mem[9], 32'h0000_DEAD);
    while (acc_addr.size() > 0) pipe_read("starve_wr_landed", acc_addr.pop_front());

    // len = 0: done pulse right after start, no dump activity
    lat_exp = 1;
    start_dump(5, 0);
    check("len0_done_now", done_cnt, done_base + 1);
    repeat (2) cycle();
    check("len0_no_busy", busy_cnt, 0);
    check("len0_no_valid", dbg_valid, 1'b0);

    // Address wrap
    start_dump(1023, 2);
    run_until_done("wrap", 100);

    // Start while busy is ignored
    start_dump(5, 3);
    cycle();
    dbg_start = 1'b1; dbg_base = 10'd1023; dbg_len = 10'd2;
    cycle();
    dbg_start = 1'b0;
    run_until_done("busy_start", 100);
    done_base = done_cnt;
    repeat (10) cycle();
    check("busy_start_no_extra", done_cnt, done_base);
    check("busy_start_idle", dbg_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
